// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter: compare op codes and the
// illegal-code check used by the arbiter when capturing per-port errors.
package cmp_pkg;

  localparam int NREQ_DEF = 2;

  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;

  function automatic logic cmp_ctrl_illegal(input logic [2:0] ctrl);
    return (ctrl == 3'b000) || (ctrl == 3'b111);
  endfunction

endpackage

// File: rtl/cmp_32.sv
// Single-cycle 32-bit comparator. LT/GE are signed, LTU/GEU unsigned;
// illegal op codes produce c = 0.
module cmp_32
  import cmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic        c
);

  always_comb begin
    c = 1'b0;
    case (ctrl)
      CMP_EQ:  c = (a == b);
      CMP_NE:  c = (a != b);
      CMP_LT:  c = ($signed(a) < $signed(b));
      CMP_LTU: c = (a < b);
      CMP_GE:  c = ($signed(a) >= $signed(b));
      CMP_GEU: c = (a >= b);
      default: c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-port round-robin front end for one shared cmp_32. Each port captures its
// result on grant and holds it until the consumer takes it.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [31:0]       req_a    [NREQ],
  input  logic [31:0]       req_b    [NREQ],
  input  logic [2:0]        req_ctrl [NREQ],
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [NREQ-1:0]   resp_c,
  output logic [NREQ-1:0]   resp_err,
  output logic [CNT_W-1:0]  cmp_count,
  output logic              dbg_prio
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_ready is the grant, resp_valid doubles as the port state
  // (0 = IDLE, 1 = PEND) and only drops when resp_ready takes the result.

  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [NREQ-1:0]  resp_c_q, resp_c_d;
  logic [NREQ-1:0]  resp_err_q, resp_err_d;
  logic [CNT_W-1:0] cmp_count_q, cmp_count_d;
  logic             prio_q, prio_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic             sel;
  logic [31:0]      mux_a, mux_b;
  logic [2:0]       mux_ctrl;
  logic             cmp_c;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = rst_n & req_valid[i] & (~resp_valid_q[i] | resp_ready[i]);
    end
    grant = elig;
    if (&elig) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
    sel      = grant[1];
    mux_a    = req_a[sel];
    mux_b    = req_b[sel];
    mux_ctrl = req_ctrl[sel];
  end

  cmp_32 u_cmp (
    .a    (mux_a),
    .b    (mux_b),
    .ctrl (mux_ctrl),
    .c    (cmp_c)
  );

  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
    resp_valid_d = resp_valid_q;
    resp_c_d     = resp_c_q;
    resp_err_d   = resp_err_q;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_d[i] = grant[i] | (resp_valid_q[i] & ~resp_ready[i]);
      if (grant[i]) begin
        resp_c_d[i]   = cmp_c;
        resp_err_d[i] = cmp_ctrl_illegal(mux_ctrl);
      end
    end
    cmp_count_d = cmp_count_q;
    if ((|grant) && (cmp_count_q != '1)) begin
      cmp_count_d = cmp_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_c_q     <= '0;
      resp_err_q   <= '0;
      cmp_count_q  <= '0;
      prio_q       <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_c_q     <= resp_c_d;
      resp_err_q   <= resp_err_d;
      cmp_count_q  <= cmp_count_d;
      prio_q       <= prio_d;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_c     = resp_c_q;
  assign resp_err   = resp_err_q;
  assign cmp_count  = cmp_count_q;
  assign dbg_prio   = prio_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, single-port ops, contention,
// backpressure, illegal codes, mid-operation reset and counter saturation.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a    [2];
  logic [31:0] req_b    [2];
  logic [2:0]  req_ctrl [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [1:0]  resp_c;
  logic [1:0]  resp_err;
  logic [15:0] cmp_count;
  logic        dbg_prio;

  int n_vec = 0;
  int n_err = 0;

  cmp_arbiter #(.NREQ(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_c     (resp_c),
    .resp_err   (resp_err),
    .cmp_count  (cmp_count),
    .dbg_prio   (dbg_prio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are then driven 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b);
    req_ctrl[p] = ctrl;
    req_a[p]    = a;
    req_b[p]    = b;
  endtask

  initial begin
    logic [2:0] ops [4];
    logic       exps [4];
    ops[0] = CMP_LT;  exps[0] = 1'b1;
    ops[1] = CMP_LTU; exps[1] = 1'b0;
    ops[2] = CMP_GE;  exps[2] = 1'b0;
    ops[3] = CMP_GEU; exps[3] = 1'b1;

    rst_n      = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    set_port(0, CMP_EQ, 32'h0, 32'h0);
    set_port(1, CMP_EQ, 32'h0, 32'h0);
    step();
    step();
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_resp_valid", resp_valid, 2'b00);
    chk("reset_resp_c", resp_c, 2'b00);
    chk("reset_resp_err", resp_err, 2'b00);
    chk("reset_count", cmp_count, 16'd0);
    chk("reset_prio", dbg_prio, 1'b0);

    // Single EQ on port 0
    rst_n     = 1'b1;
    req_valid = 2'b00;
    step();
    chk("idle_ready", req_ready, 2'b00);
    set_port(0, CMP_EQ, 32'h12345678, 32'h12345678);
    req_valid = 2'b01;
    #1;
    chk("eq_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("eq_resp_valid", resp_valid, 2'b01);
    chk("eq_resp_c", resp_c[0], 1'b1);
    chk("eq_resp_err", resp_err[0], 1'b0);
    chk("eq_count", cmp_count, 16'd1);
    chk("eq_prio", dbg_prio, 1'b1);
    resp_ready = 2'b01;
    step();
    chk("eq_consumed", resp_valid, 2'b00);

    // Signed/unsigned split on port 1, one result per cycle
    resp_ready = 2'b10;
    req_valid  = 2'b10;
    for (int k = 0; k < 4; k++) begin
      set_port(1, ops[k], 32'hFFFF_FFFF, 32'h0000_0001);
      #1;
      chk("split_req_ready", req_ready, 2'b10);
      step();
      chk("split_resp_valid", resp_valid[1], 1'b1);
      chk($sformatf("split_c_op%0d", ops[k]), resp_c[1], exps[k]);
      chk("split_err", resp_err[1], 1'b0);
    end
    req_valid = 2'b00;
    chk("split_count", cmp_count, 16'd5);
    step();
    chk("split_drained", resp_valid, 2'b00);

    // Contention from reset: grants alternate starting at port 0
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    set_port(0, CMP_EQ, 32'h5, 32'h5);
    set_port(1, CMP_NE, 32'h5, 32'h5);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("contend_grant%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req_valid = 2'b00;
    chk("contend_count", cmp_count, 16'd6);
    chk("contend_c", resp_c, 2'b01);
    step();
    chk("contend_drained", resp_valid, 2'b00);
    chk("contend_prio", dbg_prio, 1'b0);

    // Backpressure: port 0 pending and stalled, port 1 takes every slot
    set_port(0, CMP_LTU, 32'h1, 32'h2);
    resp_ready = 2'b00;
    req_valid  = 2'b01;
    step();
    chk("bp_first_valid", resp_valid, 2'b01);
    chk("bp_first_c", resp_c[0], 1'b1);
    set_port(0, 3'b000, 32'h7, 32'h7);
    set_port(1, CMP_EQ, 32'h9, 32'h9);
    req_valid  = 2'b11;
    resp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_grant%0d", k), req_ready, 2'b10);
      step();
      chk("bp_hold_valid", resp_valid[0], 1'b1);
      chk("bp_hold_c", resp_c[0], 1'b1);
      chk("bp_hold_err", resp_err[0], 1'b0);
    end
    chk("bp_count", cmp_count, 16'd12);
    resp_ready = 2'b11;
    #1;
    chk("bp_release_grant", req_ready, 2'b01);
    step();
    chk("bp_refill_valid", resp_valid[0], 1'b1);
    chk("ill000_c", resp_c[0], 1'b0);
    chk("ill000_err", resp_err[0], 1'b1);
    chk("ill000_count", cmp_count, 16'd13);

    // Illegal 111 then a legal op replacing it on the same port
    req_valid = 2'b01;
    set_port(0, 3'b111, 32'h3, 32'h3);
    #1;
    chk("ill111_grant", req_ready, 2'b01);
    step();
    chk("ill111_c", resp_c[0], 1'b0);
    chk("ill111_err", resp_err[0], 1'b1);
    chk("ill111_count", cmp_count, 16'd14);
    set_port(0, CMP_EQ, 32'hA, 32'hA);
    step();
    chk("legal_after_c", resp_c[0], 1'b1);
    chk("legal_after_err", resp_err[0], 1'b0);
    chk("legal_after_count", cmp_count, 16'd15);

    // Both ports pending, then reset mid-operation
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    set_port(1, CMP_NE, 32'h1, 32'h2);
    step();
    chk("pend_both_a", resp_valid, 2'b11);
    req_valid  = 2'b11;
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("pend_both_b", resp_valid, 2'b11);
    chk("pend_prio", dbg_prio, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", req_ready, 2'b00);
    step();
    chk("midreset_valid", resp_valid, 2'b00);
    chk("midreset_prio", dbg_prio, 1'b0);
    chk("midreset_count", cmp_count, 16'd0);
    chk("midreset_c", resp_c, 2'b00);

    // Counter saturation: drive port 1 up to and beyond all-ones
    rst_n      = 1'b1;
    req_valid  = 2'b10;
    resp_ready = 2'b10;
    set_port(1, CMP_EQ, 32'h0, 32'h0);
    repeat (65533) step();
    chk("sat_near", cmp_count, 16'hFFFD);
    repeat (3) step();
    chk("sat_full", cmp_count, 16'hFFFF);
    step();
    chk("sat_hold", cmp_count, 16'hFFFF);
    req_valid = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
